reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_reg_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// Debug GPR access controller: accepts one read/write request at a time,
// stalls the core, performs a single-cycle register-file access while the
// core is halted, then returns one response with an error flag.
module reg_access_ctrl #(
    parameter int unsigned HALT_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [4:0]  ReqAddr,
    input  logic [31:0] ReqWdata,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspData,
    output logic        RspErr,
    output logic        HaltReq,
    input  logic        Halted,
    output logic [4:0]  RfAddrRs,
    input  logic [31:0] RfRdData,
    output logic [4:0]  RfAddrRd,
    output logic [31:0] RfWrData,
    output logic        RfRegWrite
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HALT_WAIT = 2'd1,
        ACCESS    = 2'd2,
        RESP      = 2'd3
    } state_e;

    // Last counter value before the halt wait gives up.
    localparam logic [7:0] CNT_LAST = 8'(HALT_TIMEOUT - 1);

    state_e      state_q,    state_d;
    logic        write_q,    write_d;
    logic [4:0]  addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [7:0]  cnt_q,      cnt_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q,  rsp_err_d;

    // State and captured-request registers.
    // NOTE: every flop here has a reset value, so nothing captured from an
    // aborted request survives Rst_n; sequential state uses <= only so all
    // registers update together from the values of the previous cycle.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            addr_q     <= 5'd0;
            wdata_q    <= 32'd0;
            cnt_q      <= 8'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Next-state logic and per-state handshake / register-file strobes.
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        ReqReady   = 1'b0;
        HaltReq    = 1'b1;
        RspValid   = 1'b0;
        RfRegWrite = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so nothing looks
                // acceptable before the block is out of reset.
                ReqReady = Rst_n;
                HaltReq  = 1'b0;
                if (ReqValid && Rst_n) begin
                    write_d    = ReqWrite;
                    addr_d     = ReqAddr;
                    wdata_d    = ReqWdata;
                    cnt_d      = 8'd0;
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b0;
                    state_d    = HALT_WAIT;
                end
            end

            HALT_WAIT: begin
                if (Halted) begin
                    state_d = ACCESS;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ACCESS: begin
                state_d = RESP;
                if (!Halted) begin
                    // Core resumed under us: touch nothing, report failure.
                    rsp_err_d  = 1'b1;
                    rsp_data_d = 32'd0;
                end else if (write_q) begin
                    // x0 is hardwired; the write completes without a strobe.
                    RfRegWrite = (addr_q != 5'd0);
                    rsp_err_d  = 1'b0;
                    rsp_data_d = 32'd0;
                end else begin
                    rsp_err_d  = 1'b0;
                    rsp_data_d = RfRdData;
                end
            end

            RESP: begin
                RspValid = 1'b1;
                if (RspReady) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The register-file address/data buses simply present the captured request.
    assign RfAddrRs = addr_q;
    assign RfAddrRd = addr_q;
    assign RfWrData = wdata_q;
    assign RspData  = rsp_data_q;
    assign RspErr   = rsp_err_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench for reg_access_ctrl: a directed vector table, reset
// sequences, then randomized transactions scored against a transaction-level
// model of the access rules.
module tb_reg_access_ctrl;

    localparam int T = 16;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [4:0]  ReqAddr = 5'd0;
    logic [31:0] ReqWdata = 32'd0;
    logic        RspValid;
    logic        RspReady = 1'b0;
    logic [31:0] RspData;
    logic        RspErr;
    logic        HaltReq;
    logic        Halted = 1'b0;
    logic [4:0]  RfAddrRs;
    logic [31:0] RfRdData;
    logic [4:0]  RfAddrRd;
    logic [31:0] RfWrData;
    logic        RfRegWrite;

    int n_vec = 0;
    int n_err = 0;
    int exp_writes = 0;
    int wr_seen = 0;

    // Register file seen by the DUT, and the model's own copy of it.
    logic [31:0] rf     [32] = '{default: 32'h0};
    logic [31:0] shadow [32] = '{default: 32'h0};

    reg_access_ctrl #(.HALT_TIMEOUT(T)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .ReqValid   (ReqValid),
        .ReqReady   (ReqReady),
        .ReqWrite   (ReqWrite),
        .ReqAddr    (ReqAddr),
        .ReqWdata   (ReqWdata),
        .RspValid   (RspValid),
        .RspReady   (RspReady),
        .RspData    (RspData),
        .RspErr     (RspErr),
        .HaltReq    (HaltReq),
        .Halted     (Halted),
        .RfAddrRs   (RfAddrRs),
        .RfRdData   (RfRdData),
        .RfAddrRd   (RfAddrRd),
        .RfWrData   (RfWrData),
        .RfRegWrite (RfRegWrite)
    );

    always #5 Clk = ~Clk;

    assign RfRdData = (RfAddrRs == 5'd0) ? 32'd0 : rf[RfAddrRs];

    always @(posedge Clk) begin
        if (RfRegWrite) begin
            wr_seen <= wr_seen + 1;
            if (RfAddrRd != 5'd0) rf[RfAddrRd] <= RfWrData;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".ReqReady"},   ReqReady,   0);
        check({tag, ".RspValid"},   RspValid,   0);
        check({tag, ".RspErr"},     RspErr,     0);
        check({tag, ".RspData"},    RspData,    0);
        check({tag, ".HaltReq"},    HaltReq,    0);
        check({tag, ".RfRegWrite"}, RfRegWrite, 0);
        check({tag, ".RfAddrRs"},   RfAddrRs,   0);
        check({tag, ".RfAddrRd"},   RfAddrRd,   0);
        check({tag, ".RfWrData"},   RfWrData,   0);
    endtask

    // Transaction-level rules: when the access happens, and what it returns.
    function automatic bit halt_in_time(input int hd);
        return ((hd < 1) ? 1 : hd) <= T;
    endfunction

    function automatic logic [32:0] model_rsp(input logic wr, input logic [4:0] a,
                                              input int hd, input bit drop);
        if (!halt_in_time(hd) || drop) return {1'b1, 32'd0};
        if (wr) return {1'b0, 32'd0};
        return {1'b0, (a == 5'd0) ? 32'd0 : shadow[a]};
    endfunction

    // Runs one request from IDLE through the response handshake. Halted rises
    // in the hd-th cycle after accept (hd<=0: already high at accept), is
    // optionally dropped in the access cycle, and RspReady is withheld for
    // rsp_wait response cycles. Unrelated request noise is driven while busy.
    task automatic run_txn(input logic wr, input logic [4:0] a, input logic [31:0] d,
                           input int hd, input bit drop, input int rsp_wait,
                           output logic err_o, output logic [31:0] data_o);
        int acc_c, resp_c, hs_c;
        bit expect_wr;
        string tag;
        tag = $sformatf("%s x%0d", wr ? "wr" : "rd", a);
        if (halt_in_time(hd)) begin
            acc_c  = ((hd < 1) ? 1 : hd) + 1;
            resp_c = acc_c + 1;
        end else begin
            acc_c  = -1;
            resp_c = T + 1;
        end
        hs_c      = resp_c + rsp_wait;
        expect_wr = (acc_c > 0) && wr && (a != 5'd0) && !drop;
        err_o     = 1'b0;
        data_o    = 32'd0;

        check({tag, " ready_idle"}, ReqReady, 1);
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWdata = d;
        Halted   = (hd <= 0);
        RspReady = 1'b0;
        @(posedge Clk); #1;
        for (int c = 1; c <= hs_c; c++) begin
            ReqValid = 1'($urandom_range(0, 1));
            ReqWrite = 1'($urandom_range(0, 1));
            ReqAddr  = 5'($urandom);
            ReqWdata = $urandom;
            Halted   = (c >= hd) && !(drop && c == acc_c);
            RspReady = (c == hs_c);
            #1;
            check({tag, " busy_ready"}, ReqReady, 0);
            check({tag, " halt_req"},   HaltReq,  1);
            check({tag, " rf_addr"},    {RfAddrRs, RfAddrRd}, {a, a});
            check({tag, " rf_wdata"},   RfWrData, d);
            check({tag, " rf_we"},      RfRegWrite, 32'((c == acc_c) && expect_wr));
            check({tag, " rsp_valid"},  RspValid,   32'(c >= resp_c));
            if (c == resp_c) begin
                err_o  = RspErr;
                data_o = RspData;
            end else if (c > resp_c) begin
                check({tag, " rsp_stable"}, {RspErr, RspData[30:0]}, {err_o, data_o[30:0]});
                check({tag, " rsp_data_stable"}, RspData, data_o);
            end
            @(posedge Clk); #1;
        end
        ReqValid = 1'b0;
        RspReady = 1'b0;
        #1;
        check({tag, " post_ready"},  ReqReady, 1);
        check({tag, " post_halt"},   HaltReq,  0);
        check({tag, " post_valid"},  RspValid, 0);
        if (expect_wr) begin
            shadow[a] = d;
            exp_writes++;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        int          hd;
        bit          drop;
        int          rsp_wait;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        logic        err;
        logic [31:0] data;
        logic [32:0] exp;
        logic        r_wr;
        logic [4:0]  r_a;
        logic [31:0] r_d;
        int          r_hd;
        bit          r_drop;

        //            wr    addr   wdata          hd  drop wait  err   data
        vecs.push_back('{1'b1, 5'd5,  32'hDEADBEEF,  0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 5'd5,  32'h0,         0, 1'b0, 0, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 5'd7,  32'h12345678,  3, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 5'd7,  32'h0,         1, 1'b0, 1, 1'b0, 32'h12345678});
        vecs.push_back('{1'b0, 5'd9,  32'h0,        99, 1'b0, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 5'd9,  32'hCAFEF00D, 99, 1'b0, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 5'd9,  32'h0,         0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 5'd0,  32'hFFFFFFFF,  1, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 5'd0,  32'h0,         0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 5'd9,  32'h11112222,  1, 1'b1, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 5'd9,  32'h0,         0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 5'd5,  32'h0,         2, 1'b0, 5, 1'b0, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 5'd3,  32'h0BADF00D, 16, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 5'd3,  32'h0,        17, 1'b0, 0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 5'd3,  32'h0,         0, 1'b1, 2, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 5'd3,  32'h0,         1, 1'b0, 0, 1'b0, 32'h0BADF00D});

        // Power-on reset: outputs quiet while held, ready right after release.
        #2 Rst_n = 1'b0;
        #1 check_reset_outs("por");
        repeat (3) @(posedge Clk);
        #1 Rst_n = 1'b1;
        #1;
        check("por release ReqReady", ReqReady, 1);
        check("por release HaltReq",  HaltReq,  0);
        check("por release RfAddrRd", RfAddrRd, 0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hd,
                    vecs[i].drop, vecs[i].rsp_wait, err, data);
            check($sformatf("vec%0d RspErr", i),  err,  vecs[i].exp_err);
            check($sformatf("vec%0d RspData", i), data, vecs[i].exp_data);
        end

        // Reset during HALT_WAIT of a write: abort with no strobe and no response.
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 5'd12; ReqWdata = 32'hA5A5A5A5;
        Halted   = 1'b1;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        check("midrst HaltReq before reset", HaltReq, 1);
        Rst_n = 1'b0;
        #1 check_reset_outs("midrst");
        for (int k = 0; k < 3; k++) begin
            @(posedge Clk); #1;
            check("midrst held RfRegWrite", RfRegWrite, 0);
            check("midrst held RspValid",   RspValid,   0);
        end
        Rst_n = 1'b1;
        #1;
        check("midrst release ReqReady", ReqReady, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge Clk); #1;
            check("midrst idle HaltReq",    HaltReq,    0);
            check("midrst idle RspValid",   RspValid,   0);
            check("midrst idle RfRegWrite", RfRegWrite, 0);
            check("midrst idle RfAddrRd",   RfAddrRd,   0);
        end
        run_txn(1'b0, 5'd12, 32'h0, 0, 1'b0, 0, err, data);
        check("midrst readback RspErr",  err,  0);
        check("midrst readback RspData", data, 0);

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_a    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            r_d    = $urandom;
            r_hd   = int'($urandom_range(0, 19));
            r_drop = ($urandom_range(0, 7) == 0);
            exp    = model_rsp(r_wr, r_a, r_hd, r_drop);
            run_txn(r_wr, r_a, r_d, r_hd, r_drop, int'($urandom_range(0, 3)), err, data);
            check($sformatf("rand%0d RspErr", n),  err,  exp[32]);
            check($sformatf("rand%0d RspData", n), data, exp[31:0]);
        end

        check("total RF write strobes", wr_seen, exp_writes);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
